hazard_scoreboard: RTL

- Centralised hazard controller for the 5-stage Fetch/Decode/Execute/Memory/Writeback pipeline.
- Tracks in-flight destination registers with per-register pending counters, set at Decode issue and cleared at Writeback retire.
- Sequences branch stalls with a small FSM and produces the dependency-stall and branch-stall signals consumed by Fetch and Decode.
- Keeps saturating stall-cycle performance counters and a sticky protocol-error flag for the LED/HEX debug path.

---
 rtl/hazard_scoreboard_pkg.sv | 13 +
 rtl/hazard_scoreboard_sb_counter.sv | 33 +++
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared widths and branch FSM encoding for the hazard scoreboard
package hazard_scoreboard_pkg;

  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 1 << REG_IDX_W;
  localparam int CNT_W     = 2;

  typedef enum logic {
    BR_IDLE    = 1'b0,
    BR_PENDING = 1'b1
  } br_state_t;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// rtl/hazard_scoreboard_sb_counter.sv - per-register pending-write counter with underflow flag
module sb_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  // A retire with nothing outstanding is a protocol violation; the count is left at zero.
  assign underflow = dec & ~inc & (count == '0);

  // Count up on issue, down on retire; simultaneous issue and retire cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc & ~dec) begin
      if (count != CNT_W'(MAX_COUNT)) begin
        count <= count + 1'b1;
      end
    end else if (dec & ~inc) begin
      if (count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - dependency/branch stall controller with pending-write tracking and stall counters
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT  = 3,
  parameter bit RETIRE_BYPASS = 1'b1,
  parameter int PERF_W        = 16
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET,
  input  logic                 I_IssueValid,
  input  logic                 I_IssueWritesReg,
  input  logic [REG_IDX_W-1:0] I_IssueDestIdx,
  input  logic                 I_Src1Used,
  input  logic [REG_IDX_W-1:0] I_Src1Idx,
  input  logic                 I_Src2Used,
  input  logic [REG_IDX_W-1:0] I_Src2Idx,
  input  logic                 I_IssueIsBranch,
  input  logic                 I_BranchResolve,
  input  logic                 I_RetireValid,
  input  logic [REG_IDX_W-1:0] I_RetireIdx,
  output logic                 O_DepStall,
  output logic                 O_BranchStall,
  output logic                 O_IssueAccept,
  output logic [NUM_REGS-1:0]  O_PendingMask,
  output logic [PERF_W-1:0]    O_DepStallCount,
  output logic [PERF_W-1:0]    O_BranchStallCount,
  output logic                 O_Error
);

  logic [CNT_W-1:0]    count [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] uflow;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] at_max;
  br_state_t           state;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      assign inc[g] = O_IssueAccept & I_IssueWritesReg & (I_IssueDestIdx == REG_IDX_W'(g));
      assign dec[g] = I_RetireValid & (I_RetireIdx == REG_IDX_W'(g));

      sb_counter #(
        .MAX_COUNT(MAX_INFLIGHT)
      ) u_cnt (
        .clk      (I_CLOCK),
        .rst      (I_RESET),
        .inc      (inc[g]),
        .dec      (dec[g]),
        .count    (count[g]),
        .underflow(uflow[g])
      );

      assign O_PendingMask[g] = (count[g] != '0);
      // The last outstanding write retiring this cycle already has its value on the writeback path.
      assign busy[g]   = O_PendingMask[g] & ~(RETIRE_BYPASS & dec[g] & (count[g] == CNT_W'(1)));
      assign at_max[g] = (count[g] == CNT_W'(MAX_INFLIGHT));
    end
  endgenerate

  assign O_DepStall = I_IssueValid & ((I_Src1Used & busy[I_Src1Idx]) |
                                      (I_Src2Used & busy[I_Src2Idx]) |
                                      (I_IssueWritesReg & at_max[I_IssueDestIdx]));
  assign O_BranchStall = (state == BR_PENDING);
  assign O_IssueAccept = I_IssueValid & ~O_DepStall & ~O_BranchStall;

  // Branch sequencing: one unresolved branch blocks further issue until the cycle after resolve.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state <= BR_IDLE;
    end else begin
      case (state)
        BR_IDLE:    if (O_IssueAccept & I_IssueIsBranch) state <= BR_PENDING;
        BR_PENDING: if (I_BranchResolve) state <= BR_IDLE;
        default:    state <= BR_IDLE;
      endcase
    end
  end

  // Sticky error: retire of an idle register or a resolve with no branch outstanding.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      O_Error <= 1'b0;
    end else if ((|uflow) | (I_BranchResolve & (state == BR_IDLE))) begin
      O_Error <= 1'b1;
    end
  end

  // Saturating stall-cycle counters for the debug display.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      O_DepStallCount    <= '0;
      O_BranchStallCount <= '0;
    end else begin
      if (O_DepStall && !(&O_DepStallCount)) begin
        O_DepStallCount <= O_DepStallCount + 1'b1;
      end
      if (O_BranchStall && !(&O_BranchStallCount)) begin
        O_BranchStallCount <= O_BranchStallCount + 1'b1;
      end
    end
  end

endmodule
